// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one memory port between the instruction fetch (IFU) and the
//   load/store (LSU) requesters. Only one transaction is in flight at a time.
//   A granted request is latched and held on the memory side until it is
//   taken, and the memory response is routed back to the requester that
//   issued it.
//
//   Build option:
//     ARB_RR_EN  defined   -> ties alternate between the requesters,
//                             starting with IFU after reset.
//     ARB_RR_EN  undefined -> fixed priority: LSU wins ties.
//   A lone requester is always granted in both modes.

module mem_port_arbiter #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,

    input  logic                 ifu_req_valid,
    output logic                 ifu_req_ready,
    input  logic [WIDTH-1:0]     ifu_addr,
    output logic                 ifu_resp_valid,
    output logic [WIDTH-1:0]     ifu_rdata,

    input  logic                 lsu_req_valid,
    output logic                 lsu_req_ready,
    input  logic [WIDTH-1:0]     lsu_addr,
    input  logic                 lsu_wen,
    input  logic [WIDTH-1:0]     lsu_wdata,
    input  logic [WIDTH/8-1:0]   lsu_wstrb,
    output logic                 lsu_resp_valid,
    output logic [WIDTH-1:0]     lsu_rdata,

    output logic                 mem_req_valid,
    input  logic                 mem_req_ready,
    output logic [WIDTH-1:0]     mem_addr,
    output logic                 mem_wen,
    output logic [WIDTH-1:0]     mem_wdata,
    output logic [WIDTH/8-1:0]   mem_wstrb,
    input  logic                 mem_resp_valid,
    input  logic [WIDTH-1:0]     mem_rdata,

    output logic                 busy
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    localparam logic OWN_IFU = 1'b0;
    localparam logic OWN_LSU = 1'b1;

    logic [1:0] state;
    logic [1:0] state_nxt;
    logic       owner;
    logic       grant_ifu;
    logic       grant_lsu;
    logic       lsu_wins_tie;
    logic       resp_fire;

`ifdef ARB_RR_EN
    logic last_grant;

    // Remember who was granted last so the next tie goes to the other side.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant <= OWN_LSU;
        end else if (grant_lsu) begin
            last_grant <= OWN_LSU;
        end else if (grant_ifu) begin
            last_grant <= OWN_IFU;
        end
    end

    assign lsu_wins_tie = (last_grant == OWN_IFU);
`else
    assign lsu_wins_tie = 1'b1;
`endif

    // Grants are only made from IDLE; a lone requester always wins.
    always_comb begin
        grant_lsu = 1'b0;
        grant_ifu = 1'b0;
        if (state == ST_IDLE) begin
            grant_lsu = lsu_req_valid && (!ifu_req_valid || lsu_wins_tie);
            grant_ifu = ifu_req_valid && !(lsu_req_valid && lsu_wins_tie);
        end
    end

    // Transaction sequencing: accept -> present to memory -> await response.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (grant_ifu || grant_lsu) state_nxt = ST_REQ;
            ST_REQ:  if (mem_req_ready)          state_nxt = ST_RESP;
            ST_RESP: if (mem_resp_valid)         state_nxt = ST_IDLE;
            default:                             state_nxt = ST_IDLE;
        endcase
    end

    // State register; reset drops any in-flight transaction.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Latch the granted request; fields stay put until the next grant.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner     <= OWN_IFU;
            mem_addr  <= '0;
            mem_wen   <= 1'b0;
            mem_wdata <= '0;
            mem_wstrb <= '0;
        end else if (grant_lsu) begin
            owner     <= OWN_LSU;
            mem_addr  <= lsu_addr;
            mem_wen   <= lsu_wen;
            mem_wdata <= lsu_wdata;
            mem_wstrb <= lsu_wstrb;
        end else if (grant_ifu) begin
            owner     <= OWN_IFU;
            mem_addr  <= ifu_addr;
            mem_wen   <= 1'b0;
            mem_wdata <= '0;
            mem_wstrb <= '0;
        end
    end

    assign ifu_req_ready  = grant_ifu;
    assign lsu_req_ready  = grant_lsu;
    assign mem_req_valid  = (state == ST_REQ);
    assign busy           = (state != ST_IDLE);

    assign resp_fire      = (state == ST_RESP) && mem_resp_valid;
    assign ifu_resp_valid = resp_fire && (owner == OWN_IFU);
    assign lsu_resp_valid = resp_fire && (owner == OWN_LSU);
    assign ifu_rdata      = ifu_resp_valid ? mem_rdata : '0;
    assign lsu_rdata      = lsu_resp_valid ? mem_rdata : '0;

endmodule
